multi_edge_detector: RTL
========================

# multi_edge_detector

Parametrised, multi-channel successor to the single-input rising-edge detector. Each channel synchronises a raw asynchronous input (push-button or switch), debounces it against a shared timebase tick, and emits one-clock event pulses on rising, falling or both edges. An optional auto-repeat mode produces periodic pulses while the input is held. It sits between the board buttons and the alarm-clock control FSMs, for example for set-hour/set-minute increment keys.

## Interface
- `CHANNELS`, default 4: number of independent input channels.
- `SYNC_STAGES`, default 2: synchroniser flop depth per channel; must be ≥2.
- `DEBOUNCE_TICKS`, default 16: ticks an input must stay stable before `level` follows it; must be ≥1.
- `REPEAT_DELAY`, default 64: ticks held before the first auto-repeat pulse; must be ≥1.
- `REPEAT_PERIOD`, default 16: ticks between subsequent auto-repeat pulses; must be ≥1.
- `clk` input, 1 bit: single system clock; all logic is on its rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `tick` input, 1 bit: one-clock timebase strobe (e.g. 1 kHz) that advances every counter.
- `w` input, `CHANNELS` bits: raw asynchronous inputs.
- `mode` input, `2*CHANNELS` bits: per-channel mode, with channel i in bits [2i+1:2i].
  - 00 = rising
  - 01 = falling
  - 10 = both
  - 11 = rising plus auto-repeat
- `level` output, `CHANNELS` bits: debounced, registered input level.
- `z` output, `CHANNELS` bits: registered event pulses; each pulse is exactly one `clk` wide.

## Operation
- Reset (`rst_n`=0 at a clock edge) clears all synchroniser flops, debounce counters, repeat counters, `level`, `z` and the FSM state, setting the FSM to IDLE. Reset dominates `tick` and all inputs.
- **Synchroniser:** `w[i]` passes through `SYNC_STAGES` flops to give `s[i]`.
- **Debounce:**
  - If `s[i]` equals `level[i]`, the debounce counter clears on every clock, regardless of `tick`.
  - If `s[i]` differs from `level[i]`, the counter increments on each `tick`.
  - On the clock where the counter would reach `DEBOUNCE_TICKS`, `level[i]` takes `s[i]` and the counter clears.
  - Glitches shorter than `DEBOUNCE_TICKS` ticks never reach `level`.
- **Edge event:** `z[i]` is registered on the same edge that updates `level[i]`.
  - It is set when the transition matches the mode: 0→1 for modes 00, 10 and 11; 1→0 for modes 01 and 10.
  - Otherwise `z[i]` is 0.
- **Per-channel FSM** (used only in mode 11):
  - **IDLE:** on `level` 0→1, pulse `z`, clear the repeat counter and go to HOLD.
  - **HOLD:** count ticks; at `REPEAT_DELAY` ticks, pulse `z`, clear the counter and go to REPEAT.
  - **REPEAT:** count ticks; every `REPEAT_PERIOD` ticks, pulse `z` and clear the counter.
  - From HOLD or REPEAT, `level` 1→0 returns the FSM to IDLE with no pulse on that edge.
  - The 2-bit state has a default arm that goes to IDLE.
- **Mode change** takes effect on the next clock. If `mode` ≠ 11 while the FSM is in HOLD or REPEAT, the FSM goes to IDLE, the repeat counter clears, and no pulse is issued.
- Channels are fully independent; simultaneous events on several channels all pulse in the same cycle.
- **Width rules:**
  - The debounce counter is `$clog2(DEBOUNCE_TICKS+1)` bits.
  - The repeat counter is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)` bits.
  - Counters saturate-free by construction: they are cleared on reaching their terminal value and never wrap.

## Timing
- `w` to `level` latency is `SYNC_STAGES` clocks plus `DEBOUNCE_TICKS` ticks, measured to the terminal tick's clock edge.
- `z` coincides with the `level` change: 0 cycles after `level`, both registered on the same edge.
- An auto-repeat pulse occurs on the clock edge of the terminal `tick`.
- `z` is never high on two consecutive clocks for one channel. This holds because `tick` must not be asserted on consecutive clocks, which is a system requirement.
- Releasing `rst_n` while `w`=1: `level` rises after the full debounce and `z` pulses if the mode includes rising. An input held through reset is reported as a fresh press.
- Reset asserted mid-HOLD or mid-REPEAT: the clock after the reset edge has `z`=0 and `level`=0.

## Structure
- **Shared package `edge_detector_pkg`:**
  - mode constants: `MODE_RISE`, `MODE_FALL`, `MODE_BOTH`, `MODE_REPEAT`
  - FSM state encoding: `ST_IDLE`=00, `ST_HOLD`=01, `ST_REPEAT`=10
- **Sub-module `edge_channel`:** one channel containing the synchroniser, debounce counter, FSM and repeat counter. The top level instantiates `CHANNELS` copies in a generate loop and fans out `tick`.

## Test plan
1. Defaults, `tick` every 4 clk, mode 00. Raise `w[0]` and hold → `level[0]` rises after 2 clk + 16 ticks with a single 1-clk `z[0]`. Release → no `z`.
2. Mode 10. Apply a 5-tick glitch on `w[1]`, then a clean press and release → no activity for the glitch, then exactly 2 pulses, one on each clean edge.
3. Mode 11. Hold `w[2]` for 64+3×16+5 ticks after debounce, then release → pulses at debounce, +64, +80, +96 and +112 ticks (5 total), none on release.
4. Mode 11. Switch to mode 00 during REPEAT → no further pulses. Switch back to 11 while still held → no pulse until a new press.
5. Press all channels in the same cycle with mixed modes → matching channels pulse together, the others stay 0.
6. Assert `rst_n`=0 mid-REPEAT with `w` held, then release → `z`=0 and `level`=0 the clock after reset. After 16 ticks, `level`=1 with one fresh `z` pulse.

Source files
------------

// File: rtl/multi_edge_detector_pkg.sv
// edge_detector_pkg: shared definitions for the multi-channel edge detector.
//   - per-channel mode encodings (2 bits per channel on the mode bus)
//   - auto-repeat FSM state encoding
//   - max_int helper used to size the repeat counter
package edge_detector_pkg;

  localparam logic [1:0] MODE_RISE   = 2'b00;
  localparam logic [1:0] MODE_FALL   = 2'b01;
  localparam logic [1:0] MODE_BOTH   = 2'b10;
  localparam logic [1:0] MODE_REPEAT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HOLD   = 2'b01,
    ST_REPEAT = 2'b10
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_edge_detector_if.sv
// multi_edge_detector_if: bundles the timebase, raw inputs, mode bus and the
// detector outputs.
//   tick      : one-clock timebase strobe (master -> slave)
//   w         : raw asynchronous inputs, one bit per channel (master -> slave)
//   mode      : 2 bits per channel, channel i in [2i+1:2i] (master -> slave)
//   level     : debounced level per channel (slave -> master)
//   z         : one-clock event pulses per channel (slave -> master)
//   dbg_state : auto-repeat FSM state per channel, 2 bits each (slave -> master)
//
// Signalling: there is no valid/ready pair on this bus. tick is a strobe that
// is high for exactly one clk and must never be high on two consecutive clocks;
// w is free-running and asynchronous; mode is sampled every clock; level, z and
// dbg_state are registered and valid every clock. A z pulse is consumed by
// simply observing it on the clock it is high.
interface multi_edge_detector_if #(
  parameter int CHANNELS = 4
);
  logic                  tick;
  logic [CHANNELS-1:0]   w;
  logic [2*CHANNELS-1:0] mode;
  logic [CHANNELS-1:0]   level;
  logic [CHANNELS-1:0]   z;
  logic [2*CHANNELS-1:0] dbg_state;

  modport master (
    output tick, w, mode,
    input  level, z, dbg_state
  );

  modport slave (
    input  tick, w, mode,
    output level, z, dbg_state
  );
endinterface

// File: rtl/multi_edge_detector_channel.sv
// edge_channel: one detector channel.
//   clk, rst_n : system clock, synchronous active-low reset
//   tick       : timebase strobe advancing debounce/repeat counters
//   w          : raw asynchronous input
//   mode       : 00 rise, 01 fall, 10 both, 11 rise + auto-repeat
//   level      : debounced registered level
//   z          : registered one-clock event pulse
//   state_dbg  : current auto-repeat FSM state
// SYNC_STAGES must be >= 2; DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_PERIOD >= 1.
module edge_channel
  import edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_PERIOD  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       w,
  input  logic [1:0] mode,
  output logic       level,
  output logic       z,
  output logic [1:0] state_dbg
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  // Counters compare against terminal-1 so they clear instead of reaching
  // the terminal value: the event fires on the edge of the terminal tick.
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          db_cnt;
  logic [RW-1:0]          rep_cnt;
  state_t                 state;
  logic                   s;
  logic                   settle;
  logic                   rise_evt;
  logic                   fall_evt;

  assign s         = sync_q[SYNC_STAGES-1];
  // settle: this edge is the one on which level takes the new value.
  assign settle    = (s != level) && tick && (db_cnt == DB_LAST);
  assign rise_evt  = settle && s;
  assign fall_evt  = settle && !s;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      db_cnt  <= '0;
      rep_cnt <= '0;
      level   <= 1'b0;
      z       <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], w};

      // Debounce: any return to the current level restarts the count.
      if (s == level) begin
        db_cnt <= '0;
      end else if (tick) begin
        if (db_cnt == DB_LAST) begin
          level  <= s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end

      z <= 1'b0;
      if (mode != MODE_REPEAT) begin
        // Leaving repeat mode abandons any hold in progress silently.
        state   <= ST_IDLE;
        rep_cnt <= '0;
        z       <= (rise_evt && (mode != MODE_FALL)) ||
                   (fall_evt && (mode != MODE_RISE));
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise_evt) begin
              z       <= 1'b1;
              rep_cnt <= '0;
              state   <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (fall_evt) begin
              rep_cnt <= '0;
              state   <= ST_IDLE;
            end else if (tick) begin
              if (rep_cnt == RD_LAST) begin
                z       <= 1'b1;
                rep_cnt <= '0;
                state   <= ST_REPEAT;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (fall_evt) begin
              rep_cnt <= '0;
              state   <= ST_IDLE;
            end else if (tick) begin
              if (rep_cnt == RP_LAST) begin
                z       <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
          default: begin
            rep_cnt <= '0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: CHANNELS independent synchronise/debounce/edge-detect
// channels sharing one timebase tick.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : multi_edge_detector_if slave (tick, w, mode in;
//                level, z, dbg_state out)
module multi_edge_detector
  import edge_detector_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int REPEAT_DELAY   = 64,
  parameter int REPEAT_PERIOD  = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  multi_edge_detector_if.slave bus
);

  logic [CHANNELS-1:0]   level_v;
  logic [CHANNELS-1:0]   z_v;
  logic [2*CHANNELS-1:0] state_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (bus.tick),
      .w        (bus.w[i]),
      .mode     (bus.mode[2*i +: 2]),
      .level    (level_v[i]),
      .z        (z_v[i]),
      .state_dbg(state_v[2*i +: 2])
    );
  end

  assign bus.level     = level_v;
  assign bus.z         = z_v;
  assign bus.dbg_state = state_v;

endmodule
